// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter sharing one single-port on-chip RAM between the HDMI fetcher (port 0) and the CPU (port 1).
// Latency: the grant is combinational and the access completes in its grant cycle; read data returns 1 cycle later.
// Backpressure: the losing requester sees waitrequest; the RAM never stalls. Optional macro OCM_ARB_QOS_EN selects video priority with a starvation guard.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0: HDMI pixel fetcher
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // port 1: CPU data master
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // RAM s1 slave
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic req0, req1;
  logic rd0, rd1;
  logic gnt0, gnt1;
  logic gnt_mem0, gnt_mem1;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // A master asserting read and write together is treated as a write.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign rd0  = m0_read & ~m0_write;
  assign rd1  = m1_read & ~m1_write;

`ifdef OCM_ARB_QOS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;

  // The CPU gets one beat once it has waited STARVE_LIMIT-1 contended cycles.
  assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1));

  // Video has strict priority except for the single starvation-relief beat.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~starved;
      gnt1 = starved;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Count consecutive denied CPU cycles; clear when the CPU is served or idle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1 || gnt1) begin
      starve_cnt_d = '0;
    end else begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  // Round-robin: under contention the port that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = last_grant_q;
      gnt1 = ~last_grant_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Remember the winner of every granted cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end
  end

  // Last-grant register; resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // A starvation limit below 1 has no meaning; flag it at the first clock.
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    assert property (@(posedge clk) 1'b0);
  end

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  // No RAM access may escape while reset is held.
  assign gnt_mem0 = gnt0 & ~reset;
  assign gnt_mem1 = gnt1 & ~reset;

  // Steer the granted port onto the RAM; idle cycles drive all zeros.
  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (gnt_mem0) begin
      mem_address    = m0_address;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_byteenable = m0_write ? m0_byteenable : '1;
      mem_writedata  = m0_writedata;
    end else if (gnt_mem1) begin
      mem_address    = m1_address;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_byteenable = m1_write ? m1_byteenable : '1;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_clken = 1'b1;

  // Track which port owns the read data arriving next cycle.
  always_comb begin
    rd_pend_d  = (gnt0 & rd0) | (gnt1 & rd1);
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) begin
      rd_owner_d = gnt1;
    end
  end

  // Read-return pipeline; a read granted under reset is dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
  assign m1_readdatavalid = rd_pend_q &  rd_owner_q & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  // Simultaneous read and write from one master is a protocol violation.
  assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed per vector.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: writes land on the grant edge, reads return one cycle later.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  initial begin
    ram[5]     = 32'hAAAA_0005;
    ram[6]     = 32'hBBBB_0006;
    ram[99999] = 32'hFFFF_FFFF;
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Idle after reset: nothing requested, nothing returned.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_wait0", i), 32'(m0_waitrequest), 32'd0);
      check($sformatf("idle%0d_wait1", i), 32'(m1_waitrequest), 32'd0);
      check($sformatf("idle%0d_rdv", i), {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      check($sformatf("idle%0d_cs", i), 32'(mem_chipselect), 32'd0);
      next_cycle();
    end

    // Port 0 writes then reads back address 0x10.
    m0_write = 1'b1; m0_address = 17'h00010; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    check("wr0_wait", 32'(m0_waitrequest), 32'd0);
    check("wr0_cs", 32'(mem_chipselect), 32'd1);
    check("wr0_mwrite", 32'(mem_write), 32'd1);
    check("wr0_addr", 32'(mem_address), 32'h10);
    check("wr0_wdata", mem_writedata, 32'hDEAD_BEEF);
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'h0;
    @(negedge clk);
    check("rd0_wait", 32'(m0_waitrequest), 32'd0);
    check("rd0_be", 32'(mem_byteenable), 32'hF);
    check("rd0_mwrite", 32'(mem_write), 32'd0);
    check("rd0_rdv_early", 32'(m0_readdatavalid), 32'd0);
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    check("rd0_rdv", 32'(m0_readdatavalid), 32'd1);
    check("rd0_data", m0_readdata, 32'hDEAD_BEEF);
    check("rd0_rdv1", 32'(m1_readdatavalid), 32'd0);
    check("rd0_cs_idle", 32'(mem_chipselect), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd0_rdv_once", 32'(m0_readdatavalid), 32'd0);
    next_cycle();

    // Port 1 partial write at the top address, then read back.
    m1_write = 1'b1; m1_address = 17'd99999; m1_writedata = 32'h1122_3344; m1_byteenable = 4'h3;
    @(negedge clk);
    check("bw_wait1", 32'(m1_waitrequest), 32'd0);
    check("bw_addr", 32'(mem_address), 32'd99999);
    check("bw_be", 32'(mem_byteenable), 32'h3);
    next_cycle();
    m1_write = 1'b0; m1_read = 1'b1;
    @(negedge clk);
    check("br_be", 32'(mem_byteenable), 32'hF);
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    check("br_rdv1", 32'(m1_readdatavalid), 32'd1);
    check("br_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("br_data", m1_readdata, 32'hFFFF_3344);
    next_cycle();

    // Address 0 passes straight through.
    m0_read = 1'b1; m0_address = 17'd0;
    @(negedge clk);
    check("a0_addr", 32'(mem_address), 32'd0);
    check("a0_cs", 32'(mem_chipselect), 32'd1);
    next_cycle();
    clear_inputs();
    next_cycle();

    // Fresh reset, then both masters read continuously.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 17'd5;
    m1_read = 1'b1; m1_address = 17'd6;
`ifdef OCM_ARB_QOS_EN
    // Video wins except one CPU beat every 16 cycles.
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      check($sformatf("qos%0d_wait0", k), 32'(m0_waitrequest), (k % 16 == 15) ? 32'd1 : 32'd0);
      check($sformatf("qos%0d_wait1", k), 32'(m1_waitrequest), (k % 16 == 15) ? 32'd0 : 32'd1);
      next_cycle();
    end
`else
    // Round-robin: port 0 first, then alternating; data tagged to the previous winner.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_wait0", k), 32'(m0_waitrequest), (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_wait1", k), 32'(m1_waitrequest), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_addr", k), 32'(mem_address), (k % 2 == 0) ? 32'd5 : 32'd6);
      if (k == 0) begin
        check("rr0_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      end else if ((k - 1) % 2 == 0) begin
        check($sformatf("rr%0d_rdv", k), {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd2);
        check($sformatf("rr%0d_data0", k), m0_readdata, 32'hAAAA_0005);
      end else begin
        check($sformatf("rr%0d_rdv", k), {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd1);
        check($sformatf("rr%0d_data1", k), m1_readdata, 32'hBBBB_0006);
      end
      next_cycle();
    end

    // Reset lands on a port 1 grant: the read is dropped and port 0 wins next.
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait1", 32'(m1_waitrequest), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rdv1", 32'(m1_readdatavalid), 32'd0);
    check("post_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("post_wait0", 32'(m0_waitrequest), 32'd0);
    check("post_wait1", 32'(m1_waitrequest), 32'd1);
    next_cycle();
`endif
    clear_inputs();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter that shares the single-port 32-bit on-chip frame/sprite RAM (100000 words, 17-bit word address, byte enables, 1-cycle read latency) between the HDMI pixel fetcher (port 0) and the Nios CPU data master (port 1).
- Sits between both masters and the RAM's s1 slave.
- Issues at most one RAM access per clock and routes read data back to the owning master with a pipelined readdatavalid.

Parameters:
- ADDR_W, 17, word address width on masters and RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- STARVE_LIMIT, 16, maximum consecutive cycles port 1 may wait while port 0 wins (used only with OCM_ARB_QOS_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  ADDR_W  port 0 word address.
- m0_read / m0_write  in  1 each  port 0 read / write request.
- m0_byteenable  in  DATA_W/8  port 0 byte lanes.
- m0_writedata  in  DATA_W  port 0 write data.
- m0_waitrequest  out  1  port 0 request not accepted this cycle.
- m0_readdata  out  DATA_W  port 0 read data.
- m0_readdatavalid  out  1  port 0 read data valid.
- m1_*  same set as m0_*, for port 1 (CPU).
- mem_address  out  ADDR_W  RAM address.
- mem_chipselect  out  1  RAM access strobe.
- mem_write  out  1  RAM write.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable, tied 1.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the read address cycle.

Behaviour:
- Clocking and reset: single clock domain. All state is reset synchronously by reset=1 on a clk edge.
- Requests: req_i = mi_read | mi_write. A master asserting both read and write in one cycle is illegal; write wins and an assertion fires in simulation.
- Arbitration (base): round-robin, evaluated combinationally every cycle.
  - Exactly one requester: it is granted.
  - Both requesting: grant goes to the port not equal to last_grant.
  - last_grant updates on every granted cycle; reset value is 1, so port 0 wins first contention.
- Handshake:
  - mi_waitrequest = req_i & ~grant_i (combinational).
  - An idle master sees waitrequest=0.
  - Masters hold address, data and control while waitrequest=1.
  - The RAM never stalls, so the granted access completes in its grant cycle.
- RAM drive:
  - mem_chipselect = grant0 | grant1.
  - mem_address, mem_write, mem_byteenable and mem_writedata are muxed from the granted port.
  - Reads drive mem_byteenable all-ones.
  - Idle cycle: all mem_* outputs are 0.
- Read return:
  - Register rd_pend (1 bit) and rd_owner (1 bit) on each granted read.
  - Next cycle: m[rd_owner]_readdatavalid = rd_pend, and both mi_readdata = mem_readdata (unqualified).
  - Read latency is exactly 1 cycle from grant; back-to-back reads return every cycle.
  - Writes generate no response.
- Reset values: rd_pend=0, last_grant=1, starve_cnt=0. Both readdatavalid outputs are 0 during and in the first cycle after reset.
- Reset during operation: a read granted in the same cycle as reset is discarded and no readdatavalid is returned. A write granted while reset=1 is suppressed (mem_chipselect forced 0 while reset=1).
- Boundary conditions:
  - Address 0 and address 99999 pass through unmodified.
  - No range check: addresses at or above 100000 are forwarded, and RAM behaviour there is undefined.
  - A write followed by a read to the same address in the next cycle returns the new data, since the RAM writes on the grant edge.

Optional Feature:
- Macro OCM_ARB_QOS_EN.
- Defined: port 0 (video) has strict priority with a starvation guard.
  - starve_cnt increments each cycle port 1 requests and is not granted.
  - starve_cnt clears on a port 1 grant or when port 1 is idle.
  - When starve_cnt == STARVE_LIMIT-1, port 1 wins the next contended cycle (one beat), then strict priority resumes.
  - last_grant is unused.
- Undefined: round-robin as above; starve_cnt is not instantiated.

Test Plan:
- Reset, no traffic -> both waitrequest=0, readdatavalid=0, mem_chipselect=0 for 10 cycles.
- m0 alone writes 0xDEADBEEF to address 0x00010 (byteenable 0xF), then reads it on the next cycle -> m0_waitrequest stays 0; m0_readdatavalid high exactly 1 cycle after the read grant with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Base build, m0 and m1 both continuously reading addresses 5 and 6 from reset -> grants alternate 0,1,0,1; each port's waitrequest is high on alternate cycles; returned data is tagged to the correct port.
- Byte write: m1 writes 0x11223344 with byteenable 0x3 over 0xFFFFFFFF at address 99999, then reads it -> m1_readdata=0xFFFF3344.
- Reset asserted in the same cycle as an m1 read grant -> no m1_readdatavalid in the following cycle; the next contention is won by port 0.
- With OCM_ARB_QOS_EN and STARVE_LIMIT=16, m0 and m1 requesting continuously -> m1 is granted exactly once every 16 cycles; every other cycle is granted to m0.
